// File: rtl/spart_pkg.sv
// Shared types and constants for the spart bus master: FSM states, spart
// register addresses and the baud-divisor table.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    GUARD,
    WAIT_TBR,
    WR
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;

  // Rounded divisor for a 16x oversampling spart.
  function automatic logic [15:0] div_for(input logic [1:0] br_cfg,
                                          input int unsigned clk_freq);
    int unsigned baud;
    int unsigned d;
    case (br_cfg)
      2'b00:   baud = BAUD_4800;
      2'b01:   baud = BAUD_9600;
      2'b10:   baud = BAUD_19200;
      default: baud = BAUD_38400;
    endcase
    d = (clk_freq + 8 * baud) / (16 * baud) - 1;
    return d[15:0];
  endfunction

endpackage

// File: rtl/spart_driver.sv
// Bus master for one spart: programs the baud divisor after reset or a
// baud-select change, then echoes every received byte back out.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  input  logic        rda,
  input  logic        tbr,
  output logic        cfg_done,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] echo_cnt
);

  state_t      state, state_nxt;
  logic        armed;
  logic [1:0]  br_meta, br_sync;
  logic [1:0]  cfg_sel, cfg_sel_nxt;
  logic        reconfig;
  logic [15:0] div;

  logic        iocs_nxt, iorw_nxt;
  logic [1:0]  addr_nxt;
  logic [7:0]  dout, dout_nxt;

  // Divisor follows the select being committed this cycle, so the first
  // CFG_LO write after a change already carries the new value.
  assign div = div_for(cfg_sel_nxt, CLK_FREQ);

  always_comb begin
    state_nxt   = state;
    cfg_sel_nxt = cfg_sel;
    reconfig    = 1'b0;
    case (state)
      CFG_LO:   if (armed) state_nxt = CFG_HI;
      CFG_HI:   state_nxt = IDLE;
      IDLE: begin
        if (br_sync != cfg_sel) begin
          reconfig    = 1'b1;
          cfg_sel_nxt = br_sync;
          state_nxt   = CFG_LO;
        end else if (rda) begin
          state_nxt = RD;
        end
      end
      RD:       state_nxt = GUARD;
      GUARD:    state_nxt = WAIT_TBR;
      WAIT_TBR: if (tbr) state_nxt = WR;
      WR:       state_nxt = IDLE;
      default:  state_nxt = CFG_LO;
    endcase
  end

  // Bus outputs are registered from the next state so each access lines up
  // with the cycle its state occupies; armed holds CFG_LO for one cycle out
  // of reset so its write is still issued.
  always_comb begin
    iocs_nxt = 1'b0;
    iorw_nxt = 1'b1;
    addr_nxt = ADDR_DATA;
    dout_nxt = '0;
    case (state_nxt)
      CFG_LO: begin
        iocs_nxt = 1'b1;
        iorw_nxt = 1'b0;
        addr_nxt = ADDR_DBL;
        dout_nxt = div[7:0];
      end
      CFG_HI: begin
        iocs_nxt = 1'b1;
        iorw_nxt = 1'b0;
        addr_nxt = ADDR_DBH;
        dout_nxt = div[15:8];
      end
      RD: begin
        iocs_nxt = 1'b1;
        iorw_nxt = 1'b1;
        addr_nxt = ADDR_DATA;
      end
      WR: begin
        iocs_nxt = 1'b1;
        iorw_nxt = 1'b0;
        addr_nxt = ADDR_DATA;
        dout_nxt = rx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CFG_LO;
      armed    <= 1'b0;
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= ADDR_DATA;
      dout     <= '0;
      cfg_done <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      echo_cnt <= '0;
      cfg_sel  <= br_cfg;
      br_meta  <= br_cfg;
      br_sync  <= br_cfg;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      iocs     <= iocs_nxt;
      iorw     <= iorw_nxt;
      ioaddr   <= addr_nxt;
      dout     <= dout_nxt;
      br_meta  <= br_cfg;
      br_sync  <= br_meta;
      cfg_sel  <= cfg_sel_nxt;
      rx_valid <= (state == RD);
      if (state == RD) rx_data <= databus;
      if (state == WR) echo_cnt <= echo_cnt + 16'd1;
      if (state == CFG_HI) cfg_done <= 1'b1;
      else if (reconfig) cfg_done <= 1'b0;
    end
  end

  assign databus = (iocs && !iorw) ? dout : 'z;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver with a behavioural spart on the bus.
module tb_spart_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  br_cfg;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic        rda, tbr;
  logic        cfg_done;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] echo_cnt;

  logic [7:0]  spart_rx;

  spart_driver #(.CLK_FREQ(50_000_000)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr),
    .cfg_done(cfg_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .echo_cnt(echo_cnt)
  );

  // Model spart drives the data register onto the bus during reads.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? spart_rx : 8'bz;

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] addr; logic [7:0] data; } acc_t;
  typedef struct { logic [1:0] br; logic [7:0] lo; logic [7:0] hi; } cfg_vec_t;

  acc_t        wr_q[$];
  logic [7:0]  rx_q[$];
  acc_t        e_acc;
  logic [7:0]  e_rx;
  int          checks = 0, failures = 0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_cnt = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Bus monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (iocs && !iorw) begin
        wr_cnt++;
        wr_cyc = cyc;
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%02h expected no access", ioaddr, databus);
        end else begin
          e_acc = wr_q.pop_front();
          check("write_access", {ioaddr, databus}, e_acc);
        end
        if (ioaddr[1]) check("cfg_done_low_during_cfg", cfg_done, 1'b0);
      end
      if (iocs && iorw) begin
        rd_cnt++;
        rd_cyc = cyc;
        check("read_addr", ioaddr, 2'b00);
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_valid: got rx_data=%02h expected no pulse", rx_data);
        end else begin
          e_rx = rx_q.pop_front();
          check("rx_data", rx_data, e_rx);
        end
      end
    end
  end

  task automatic wait_rd(input int start);
    int n = 0;
    while (rd_cnt == start && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (rd_cnt == start) timeout("read_wait");
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (wr_cnt < target) timeout("write_wait");
  endtask

  task automatic wait_cfg_done();
    int n = 0;
    while (!cfg_done && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("cfg_done_set", cfg_done, 1'b1);
  endtask

  // Present a byte with rda and drop rda once the driver has read it.
  task automatic send(input logic [7:0] b);
    int rs;
    rs = rd_cnt;
    spart_rx = b;
    rx_q.push_back(b);
    wr_q.push_back({2'b00, b});
    rda = 1'b1;
    wait_rd(rs);
    rda = 1'b0;
  endtask

  cfg_vec_t   cfg_tab[4];
  logic [7:0] echo_tab[5];

  initial begin
    int ws, t;
    cfg_tab[0] = '{2'b00, 8'h8A, 8'h02};
    cfg_tab[1] = '{2'b01, 8'h45, 8'h01};
    cfg_tab[2] = '{2'b11, 8'h50, 8'h00};
    cfg_tab[3] = '{2'b10, 8'hA2, 8'h00};
    echo_tab   = '{8'h5A, 8'h00, 8'hFF, 8'hA5, 8'h3C};

    rst = 1'b1; rda = 1'b0; tbr = 1'b1; br_cfg = 2'b00; spart_rx = '0;

    // Reset state and divisor programming for every baud select.
    foreach (cfg_tab[i]) begin
      rst = 1'b1;
      br_cfg = cfg_tab[i].br;
      repeat (2) @(negedge clk);
      check("rst_iocs", iocs, 1'b0);
      check("rst_iorw", iorw, 1'b1);
      check("rst_ioaddr", ioaddr, 2'b00);
      check("rst_cfg_done", cfg_done, 1'b0);
      check("rst_echo_cnt", echo_cnt, 16'h0000);
      check("rst_rx", {rx_valid, rx_data}, 9'h000);
      rst = 1'b0;
      @(negedge clk);
      check("cfg_lo_access", {iocs, iorw, ioaddr}, 4'b1010);
      check("cfg_lo_data", databus, cfg_tab[i].lo);
      @(negedge clk);
      check("cfg_hi_access", {iocs, iorw, ioaddr}, 4'b1011);
      check("cfg_hi_data", databus, cfg_tab[i].hi);
      check("cfg_done_during_hi", cfg_done, 1'b0);
      @(negedge clk);
      check("cfg_done_after_hi", {cfg_done, iocs}, 2'b10);
    end
    mon_en = 1'b1;

    // Echo loop with tbr already high: write lands 3 cycles after the read.
    foreach (echo_tab[i]) begin
      ws = wr_cnt;
      send(echo_tab[i]);
      wait_wr(ws + 1);
      check("echo_latency", wr_cyc - rd_cyc, 3);
      @(negedge clk);
      exp_cnt++;
      check("echo_cnt", echo_cnt, exp_cnt);
    end

    // tbr held low: driver parks with the bus idle, writes the cycle after tbr rises.
    tbr = 1'b0;
    ws = wr_cnt;
    send(8'h77);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      check("wait_tbr_bus_idle", iocs, 1'b0);
    end
    tbr = 1'b1;
    t = cyc;
    wait_wr(ws + 1);
    check("tbr_to_write", wr_cyc - t, 1);
    @(negedge clk);
    exp_cnt++;
    check("echo_cnt_tbr", echo_cnt, exp_cnt);

    // Baud change while waiting on tbr: echo first, then reprogram for 4800.
    tbr = 1'b0;
    ws = wr_cnt;
    send(8'h99);
    repeat (3) @(negedge clk);
    br_cfg = 2'b00;
    wr_q.push_back({2'b10, 8'h8A});
    wr_q.push_back({2'b11, 8'h02});
    repeat (6) @(negedge clk);
    #1;
    check("cfg_held_in_flight", {cfg_done, iocs}, 2'b10);
    tbr = 1'b1;
    wait_wr(ws + 3);
    exp_cnt++;
    wait_cfg_done();
    check("echo_cnt_reconfig", echo_cnt, exp_cnt);
    check("reconfig_queue_drained", wr_q.size(), 0);

    // Counter wrap from FFFF.
    force dut.echo_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.echo_cnt;
    exp_cnt = 16'hFFFF;
    ws = wr_cnt;
    send(8'hC7);
    wait_wr(ws + 1);
    @(negedge clk);
    exp_cnt++;
    check("echo_cnt_wrap", echo_cnt, exp_cnt);

    // Asynchronous reset in the middle of a WR access.
    tbr = 1'b0;
    send(8'hE1);
    repeat (3) @(negedge clk);
    tbr = 1'b1;
    @(posedge clk); #1;
    check("wr_before_reset", {iocs, iorw, ioaddr}, 4'b1000);
    rst = 1'b1;
    #1;
    check("async_rst_iocs", {iocs, iorw}, 2'b01);
    check("async_rst_state", {cfg_done, echo_cnt}, 17'h0);
    wr_q.delete();
    rx_q.delete();
    wr_q.push_back({2'b10, 8'h8A});
    wr_q.push_back({2'b11, 8'h02});
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_cfg_done();
    check("post_reset_cfg_first", wr_q.size(), 0);

    ws = wr_cnt;
    send(8'h3E);
    wait_wr(ws + 1);
    @(negedge clk);
    exp_cnt++;
    check("echo_cnt_post_reset", echo_cnt, exp_cnt);
    check("final_queues_empty", wr_q.size() + rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
